// File: rtl/icache_refill.sv
// ---------------------------------------------------------------------------
// icache_refill
// Instruction-cache line refill engine. On a miss it fetches WORD_COUNT
// memory beats, one request outstanding at a time, assembles them into a
// cache line and pulses a single write strobe toward the cache arrays.
//
// Optional feature macro: ICACHE_REFILL_CRIT_WORD_FIRST_EN
//   defined   -> fetch starts at the missing word and wraps around the line
//   undefined -> fetch always starts at word 0 and runs in order
// Beat count and refill latency are identical in both builds.
//
// All outputs are driven straight from flops; the registered control
// outputs are loaded from the next-state decode so they line up with the
// state they describe.
// ---------------------------------------------------------------------------
module icache_refill #(
    parameter int BLOCK_WIDTH = 512,
    parameter int WORD_SIZE   = 32,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic                   i_miss,
    input  logic [ADDR_WIDTH-1:0]  i_miss_addr,
    output logic                   o_mem_req_valid,
    input  logic                   i_mem_req_ready,
    output logic [ADDR_WIDTH-1:0]  o_mem_addr,
    input  logic                   i_mem_rdata_valid,
    input  logic [WORD_SIZE-1:0]   i_mem_rdata,
    output logic [BLOCK_WIDTH-1:0] o_block,
    output logic                   o_write_en,
    output logic [ADDR_WIDTH-1:0]  o_refill_addr,
    output logic                   o_busy
);

    localparam int WORD_COUNT = BLOCK_WIDTH / WORD_SIZE;
    localparam int IDX_BITS   = $clog2(WORD_COUNT);
    localparam int BYTE_BITS  = $clog2(WORD_SIZE / 8);
    localparam int LINE_BITS  = IDX_BITS + BYTE_BITS;

    localparam logic [IDX_BITS-1:0] LAST_BEAT = IDX_BITS'(WORD_COUNT - 1);
    localparam logic [IDX_BITS-1:0] IDX_ONE   = IDX_BITS'(1);
    localparam logic [IDX_BITS-1:0] IDX_ZERO  = {IDX_BITS{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;

    logic [ADDR_WIDTH-1:0]   r_refill_addr;
    logic [ADDR_WIDTH-1:0]   w_refill_addr_nxt;
    logic [IDX_BITS-1:0]     r_beat_cnt;
    logic [IDX_BITS-1:0]     w_beat_cnt_nxt;
    logic [IDX_BITS-1:0]     r_word_idx;
    logic [IDX_BITS-1:0]     w_word_idx_nxt;
    logic [IDX_BITS-1:0]     w_start_idx;
    logic                    w_beat_take;

    logic [BLOCK_WIDTH-1:0]  r_block;

    logic                    r_mem_req_valid;
    logic                    r_write_en;
    logic                    r_busy;
    logic [ADDR_WIDTH-1:0]   r_mem_addr;
    logic                    w_mem_req_valid_nxt;
    logic                    w_write_en_nxt;
    logic                    w_busy_nxt;
    logic [ADDR_WIDTH-1:0]   w_mem_addr_nxt;

    // First word fetched for a new miss.
`ifdef ICACHE_REFILL_CRIT_WORD_FIRST_EN
    assign w_start_idx = i_miss_addr[LINE_BITS-1:BYTE_BITS];
`else
    assign w_start_idx = IDX_ZERO;
`endif

    // State register.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; handshake inputs only matter in their own state.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_miss) begin
                    w_next_state = S_REQ;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_REQ: begin
                if (i_mem_req_ready) begin
                    w_next_state = S_WAIT;
                end else begin
                    w_next_state = S_REQ;
                end
            end
            S_WAIT: begin
                if (i_mem_rdata_valid) begin
                    if (r_beat_cnt == LAST_BEAT) begin
                        w_next_state = S_WRITE;
                    end else begin
                        w_next_state = S_REQ;
                    end
                end else begin
                    w_next_state = S_WAIT;
                end
            end
            S_WRITE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Output/datapath decode: next values for counters, latched address and
    // the registered outputs (derived from the state being entered).
    always_comb begin
        w_refill_addr_nxt = r_refill_addr;
        w_beat_cnt_nxt    = r_beat_cnt;
        w_word_idx_nxt    = r_word_idx;
        w_beat_take       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_miss) begin
                    w_refill_addr_nxt = i_miss_addr;
                    w_beat_cnt_nxt    = IDX_ZERO;
                    w_word_idx_nxt    = w_start_idx;
                end else begin
                    w_refill_addr_nxt = r_refill_addr;
                end
            end
            S_WAIT: begin
                if (i_mem_rdata_valid) begin
                    w_beat_take = 1'b1;
                    if (r_beat_cnt != LAST_BEAT) begin
                        // 4-bit wrap keeps the fetch inside the same line.
                        w_beat_cnt_nxt = r_beat_cnt + IDX_ONE;
                        w_word_idx_nxt = r_word_idx + IDX_ONE;
                    end else begin
                        w_beat_cnt_nxt = r_beat_cnt;
                    end
                end else begin
                    w_beat_take = 1'b0;
                end
            end
            default: begin
                w_beat_take = 1'b0;
            end
        endcase

        w_mem_req_valid_nxt = (w_next_state == S_REQ);
        w_write_en_nxt      = (w_next_state == S_WRITE);
        w_busy_nxt          = (w_next_state != S_IDLE);
        w_mem_addr_nxt      = {w_refill_addr_nxt[ADDR_WIDTH-1:LINE_BITS],
                               w_word_idx_nxt,
                               {BYTE_BITS{1'b0}}};
    end

    // Latched miss address and fetch counters.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_refill_addr <= {ADDR_WIDTH{1'b0}};
            r_beat_cnt    <= IDX_ZERO;
            r_word_idx    <= IDX_ZERO;
        end else begin
            r_refill_addr <= w_refill_addr_nxt;
            r_beat_cnt    <= w_beat_cnt_nxt;
            r_word_idx    <= w_word_idx_nxt;
        end
    end

    // Line assembly: only the slot addressed by the current word index is
    // written; every other slot keeps its previous contents.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_block <= {BLOCK_WIDTH{1'b0}};
        end else begin
            for (int k = 0; k < WORD_COUNT; k++) begin
                if (w_beat_take && (r_word_idx == IDX_BITS'(k))) begin
                    r_block[k*WORD_SIZE +: WORD_SIZE] <= i_mem_rdata;
                end else begin
                    r_block[k*WORD_SIZE +: WORD_SIZE] <= r_block[k*WORD_SIZE +: WORD_SIZE];
                end
            end
        end
    end

    // Registered control outputs toward memory and the cache.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_mem_req_valid <= 1'b0;
            r_write_en      <= 1'b0;
            r_busy          <= 1'b0;
            r_mem_addr      <= {ADDR_WIDTH{1'b0}};
        end else begin
            r_mem_req_valid <= w_mem_req_valid_nxt;
            r_write_en      <= w_write_en_nxt;
            r_busy          <= w_busy_nxt;
            r_mem_addr      <= w_mem_addr_nxt;
        end
    end

    assign o_mem_req_valid = r_mem_req_valid;
    assign o_write_en      = r_write_en;
    assign o_busy          = r_busy;
    assign o_mem_addr      = r_mem_addr;
    assign o_block         = r_block;
    assign o_refill_addr   = r_refill_addr;

endmodule

// File: tb/tb_icache_refill.sv
// ---------------------------------------------------------------------------
// tb_icache_refill
// Directed bench for icache_refill with a small zero-wait memory responder.
// Expected addresses, line contents and strobe timing are computed here.
// ---------------------------------------------------------------------------
module tb_icache_refill;

    logic         clk;
    logic         arst;
    logic         i_miss;
    logic [31:0]  i_miss_addr;
    logic         o_mem_req_valid;
    logic         i_mem_req_ready;
    logic [31:0]  o_mem_addr;
    logic         i_mem_rdata_valid;
    logic [31:0]  i_mem_rdata;
    logic [511:0] o_block;
    logic         o_write_en;
    logic [31:0]  o_refill_addr;
    logic         o_busy;

    int           cyc;
    int           n_vec;
    int           n_err;
    logic [511:0] exp_block;

    icache_refill #(
        .BLOCK_WIDTH(512),
        .WORD_SIZE  (32),
        .ADDR_WIDTH (32)
    ) dut (
        .clk              (clk),
        .arst             (arst),
        .i_miss           (i_miss),
        .i_miss_addr      (i_miss_addr),
        .o_mem_req_valid  (o_mem_req_valid),
        .i_mem_req_ready  (i_mem_req_ready),
        .o_mem_addr       (o_mem_addr),
        .i_mem_rdata_valid(i_mem_rdata_valid),
        .i_mem_rdata      (i_mem_rdata),
        .o_block          (o_block),
        .o_write_en       (o_write_en),
        .o_refill_addr    (o_refill_addr),
        .o_busy           (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One complete (or aborted) refill. Memory accepts and returns data
    // without wait states except for the optional stall on one beat.
    task automatic run_refill(input logic [31:0] addr, input logic [7:0] tag,
                              input int stall_beat, input int stall_n,
                              input bit inject, input int abort_at);
        int          start;
        int          beat;
        int          stall_left;
        int          miss_cyc;
        int          wr_cnt;
        int          post;
        int          overlap;
        bit          do_inject;
        bit          miss_pend;
        logic [3:0]  s4;
        logic [31:0] exp_addr;
        logic [31:0] d;
`ifdef ICACHE_REFILL_CRIT_WORD_FIRST_EN
        start = int'(addr[5:2]);
`else
        start = 0;
`endif
        beat       = 0;
        stall_left = stall_n;
        wr_cnt     = 0;
        post       = 0;
        overlap    = 0;
        do_inject  = inject;

        @(negedge clk);
        i_miss      = 1'b1;
        i_miss_addr = addr;
        miss_cyc    = cyc;

        for (int it = 0; it < 200 && post < 3; it++) begin
            @(negedge clk);
            miss_pend = 1'b0;
            if (o_write_en && o_mem_req_valid) overlap++;
            if (wr_cnt > 0) begin
                post++;
                if (post == 1) begin
                    chk("idle_after_write_busy", 512'(o_busy), 512'(1'b0));
                end
            end
            if (o_write_en) begin
                wr_cnt++;
                if (wr_cnt == 1) begin
                    chk("latency", 512'(cyc), 512'(miss_cyc + 33 + stall_n));
                    chk("line", o_block, exp_block);
                    chk("refill_addr", 512'(o_refill_addr), 512'(addr));
                    chk("busy_in_write", 512'(o_busy), 512'(1'b1));
                end
            end
            if (o_mem_req_valid) begin
                if (abort_at > 0 && beat == abort_at) begin
                    chk("retain_unwritten", o_block, exp_block);
                    arst            = 1'b1;
                    i_mem_req_ready = 1'b1;
                    i_miss          = 1'b0;
                    @(negedge clk);
                    chk("rst_busy", 512'(o_busy), 512'(1'b0));
                    chk("rst_req_valid", 512'(o_mem_req_valid), 512'(1'b0));
                    chk("rst_write_en", 512'(o_write_en), 512'(1'b0));
                    chk("rst_block", o_block, 512'(1'b0));
                    chk("rst_refill_addr", 512'(o_refill_addr), 512'(1'b0));
                    chk("rst_mem_addr", 512'(o_mem_addr), 512'(1'b0));
                    arst      = 1'b0;
                    exp_block = '0;
                    for (int k = 0; k < 3; k++) begin
                        i_mem_rdata = 32'hFFFF_0000 + 32'(k);
                        @(negedge clk);
                        chk("late_beat_busy", 512'(o_busy), 512'(1'b0));
                        chk("late_beat_block", o_block, 512'(1'b0));
                    end
                    return;
                end
                s4       = 4'(start + beat);
                exp_addr = {addr[31:6], s4, 2'b00};
                chk("mem_addr", 512'(o_mem_addr), 512'(exp_addr));
                if (beat == stall_beat && stall_left > 0) begin
                    i_mem_req_ready = 1'b0;
                    stall_left--;
                end else begin
                    i_mem_req_ready = 1'b1;
                    d = {tag, 8'h5A, 4'h0, s4, 8'(beat)};
                    i_mem_rdata = d;
                    exp_block[32*int'(s4) +: 32] = d;
                    beat++;
                end
            end else begin
                i_mem_req_ready = 1'b1;
                if (do_inject && beat == 5 && o_busy && !o_write_en) begin
                    miss_pend = 1'b1;
                    do_inject = 1'b0;
                end
            end
            i_miss      = miss_pend;
            i_miss_addr = miss_pend ? 32'hDEAD_BEC0 : 32'h0BAD_F00C;
        end
        chk("write_count", 512'(wr_cnt), 512'(1));
        chk("no_overlap", 512'(overlap), 512'(0));
        chk("beats", 512'(beat), 512'(16));
    endtask

    initial begin
        n_vec             = 0;
        n_err             = 0;
        exp_block         = '0;
        arst              = 1'b1;
        i_miss            = 1'b0;
        i_miss_addr       = 32'h0;
        i_mem_req_ready   = 1'b1;
        i_mem_rdata_valid = 1'b1;
        i_mem_rdata       = 32'hCAFE_0000;

        repeat (3) @(negedge clk);
        chk("reset_busy", 512'(o_busy), 512'(1'b0));
        chk("reset_req_valid", 512'(o_mem_req_valid), 512'(1'b0));
        chk("reset_write_en", 512'(o_write_en), 512'(1'b0));
        chk("reset_block", o_block, 512'(1'b0));
        chk("reset_refill_addr", 512'(o_refill_addr), 512'(1'b0));
        arst = 1'b0;
        @(negedge clk);
        chk("idle_ignores_data", o_block, 512'(1'b0));
        chk("idle_busy", 512'(o_busy), 512'(1'b0));

        run_refill(32'h0000_0140, 8'h11, -1, 0, 1'b0, 0);
        run_refill(32'h0000_0158, 8'h22, -1, 0, 1'b0, 0);
        run_refill(32'h2000_0A40, 8'h33,  4, 3, 1'b0, 0);
        run_refill(32'h0000_5A64, 8'h44, -1, 0, 1'b1, 0);
        run_refill(32'h0000_03FC, 8'h55, -1, 0, 1'b0, 8);
        run_refill(32'h0000_03FC, 8'h66, -1, 0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
